// File: rtl/imem_loader.sv
// Instruction memory loader: assembles a little-endian byte stream into 32-bit
// words and writes them to consecutive word addresses while holding the core.
module imem_loader #(
   parameter int unsigned INS_ADDRESS = 9,
   parameter int unsigned INS_W       = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [INS_ADDRESS-2:0] num_words,
   input  logic                   byte_valid,
   input  logic [7:0]             byte_data,
   output logic                   byte_ready,
   output logic                   we,
   output logic [INS_ADDRESS-1:0] wa,
   output logic [INS_W-1:0]       wd,
   output logic                   cpu_hold,
   output logic                   done
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      WRITE   = 2'd2,
      DONE    = 2'd3
   } state_t;

   // Largest session that fits the address space without wa wrapping.
   localparam logic [INS_ADDRESS-2:0] MAX_WORDS = {1'b1, {(INS_ADDRESS-2){1'b0}}};
   localparam logic [INS_ADDRESS-2:0] ONE_WORD  = {{(INS_ADDRESS-2){1'b0}}, 1'b1};
   localparam logic [INS_ADDRESS-1:0] WA_STEP   = {{(INS_ADDRESS-3){1'b0}}, 3'd4};

   state_t                 state;
   state_t                 state_nxt;
   logic [1:0]             byte_cnt;
   logic [INS_ADDRESS-2:0] words_left;
   logic                   accept;

   assign accept = (state == COLLECT) && byte_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = (num_words == '0) ? DONE : COLLECT;
            end
         end
         COLLECT: begin
            if (accept && (byte_cnt == 2'd3)) begin
               state_nxt = WRITE;
            end
         end
         WRITE: begin
            state_nxt = (words_left == ONE_WORD) ? DONE : COLLECT;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // All handshake/status outputs decode the registered state only.
   assign byte_ready = (state == COLLECT);
   assign we         = (state == WRITE);
   assign cpu_hold   = (state == COLLECT) || (state == WRITE);
   assign done       = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wa         <= '0;
         wd         <= '0;
         byte_cnt   <= '0;
         words_left <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start && (num_words != '0)) begin
                  wa         <= '0;
                  byte_cnt   <= '0;
                  words_left <= (num_words > MAX_WORDS) ? MAX_WORDS : num_words;
               end
            end
            COLLECT: begin
               if (byte_valid) begin
                  unique case (byte_cnt)
                     2'd0:    wd[7:0]   <= byte_data;
                     2'd1:    wd[15:8]  <= byte_data;
                     2'd2:    wd[23:16] <= byte_data;
                     default: wd[31:24] <= byte_data;
                  endcase
                  byte_cnt <= byte_cnt + 2'd1;
               end
            end
            WRITE: begin
               if (words_left != ONE_WORD) begin
                  wa         <= wa + WA_STEP;
                  words_left <= words_left - ONE_WORD;
                  byte_cnt   <= '0;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table-driven word vectors plus hand-written sessions,
// with expected writes queued at stimulus time and popped on each we pulse.
module tb_imem_loader;

   localparam int unsigned AW = 9;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-2:0] num_words = '0;
   logic          byte_valid = 1'b0;
   logic [7:0]    byte_data = '0;
   logic          byte_ready;
   logic          we;
   logic [AW-1:0] wa;
   logic [31:0]   wd;
   logic          cpu_hold;
   logic          done;

   always #5 clk = ~clk;

   imem_loader #(.INS_ADDRESS(AW), .INS_W(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .num_words  (num_words),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .we         (we),
      .wa         (wa),
      .wd         (wd),
      .cpu_hold   (cpu_hold),
      .done       (done)
   );

   typedef struct packed {
      logic [AW-1:0] wa;
      logic [31:0]   wd;
   } wr_t;

   typedef struct {
      logic [7:0]  b0, b1, b2, b3;
      int          gap;
      logic [31:0] exp_wd;
   } vec_t;

   wr_t           exp_q[$];
   int            checks = 0;
   int            failures = 0;
   int            writes = 0;
   int            cyc = 0;
   int            last_we_cyc = 0;
   logic [AW-1:0] last_wa = '0;
   logic          prev_we = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   always @(negedge clk) begin : monitor
      wr_t e;
      if (rst_n) begin
         if (we) begin
            writes++;
            last_wa = wa;
            last_we_cyc = cyc;
            check("we_single_cycle", 32'(prev_we), 32'd0);
            check("hold_during_write", 32'(cpu_hold), 32'd1);
            if (exp_q.size() == 0) begin
               check("unexpected_write", 32'(wa), 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("write_wa", 32'(wa), 32'(e.wa));
               check("write_wd", wd, e.wd);
            end
         end
         prev_we = we;
      end else begin
         prev_we = 1'b0;
      end
   end

   task automatic begin_session(input logic [AW-2:0] n, input string tag);
      @(negedge clk);
      start = 1'b1;
      num_words = n;
      writes = 0;
      @(negedge clk);
      start = 1'b0;
      num_words = AW'($urandom) >> 1;
      if (n == 0) begin
         check({tag, "_done_now"}, 32'(done), 32'd1);
         check({tag, "_hold_low"}, 32'(cpu_hold), 32'd0);
      end else begin
         check({tag, "_hold_after_start"}, 32'(cpu_hold), 32'd1);
         check({tag, "_ready_after_start"}, 32'(byte_ready), 32'd1);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      repeat (gap) begin
         @(negedge clk);
         byte_valid = 1'b0;
         byte_data = 8'($urandom);
      end
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data = b;
      for (int i = 0; i < 20 && !byte_ready; i++) @(negedge clk);
      if (!byte_ready) check("byte_ready_timeout", 32'(byte_ready), 32'd1);
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
   endtask

   task automatic finish_session(input string tag, input int exp_writes, input int limit);
      bit found;
      @(negedge clk);
      byte_valid = 1'b0;
      found = 1'b0;
      for (int i = 0; i < limit; i++) begin
         if (done) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check({tag, "_done_seen"}, 32'(found), 32'd1);
      check({tag, "_done_after_write"}, 32'(cyc - last_we_cyc), 32'd1);
      check({tag, "_hold_at_done"}, 32'(cpu_hold), 32'd0);
      check({tag, "_write_count"}, 32'(writes), 32'(exp_writes));
      check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog simulation did not finish actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      vec_t        tbl[6];
      logic [31:0] w;

      tbl[0] = '{8'h13, 8'h00, 8'h00, 8'h00, 0, 32'h0000_0013};
      tbl[1] = '{8'h93, 8'h00, 8'h10, 8'h00, 0, 32'h0010_0093};
      tbl[2] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 1, 32'hDEAD_BEEF};
      tbl[3] = '{8'h01, 8'h02, 8'h03, 8'h04, 3, 32'h0403_0201};
      tbl[4] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 0, 32'h00FF_00FF};
      tbl[5] = '{8'hA5, 8'h5A, 8'hC3, 8'h3C, 2, 32'h3CC3_5AA5};

      repeat (2) @(negedge clk);
      check("rst_we", 32'(we), 32'd0);
      check("rst_byte_ready", 32'(byte_ready), 32'd0);
      check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_wa", 32'(wa), 32'd0);
      check("rst_wd", wd, 32'd0);
      rst_n = 1'b1;

      // Table: one six-word session, word i lands at byte address 4*i.
      begin_session(AW'(6) >> 0, "table");
      for (int i = 0; i < 6; i++) exp_q.push_back({AW'(4 * i), tbl[i].exp_wd});
      for (int i = 0; i < 6; i++) begin
         send_byte(tbl[i].b0, tbl[i].gap);
         send_byte(tbl[i].b1, tbl[i].gap);
         send_byte(tbl[i].b2, tbl[i].gap);
         send_byte(tbl[i].b3, tbl[i].gap);
      end
      finish_session("table", 6, 20);

      // Two back-to-back words.
      begin_session(8'd2, "two_words");
      exp_q.push_back({9'h000, 32'h0000_0013});
      exp_q.push_back({9'h004, 32'h0010_0093});
      send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
      send_byte(8'h93, 0); send_byte(8'h00, 0); send_byte(8'h10, 0); send_byte(8'h00, 0);
      finish_session("two_words", 2, 20);

      // Valid pattern 1,0,0,1,0,1,1.
      begin_session(8'd1, "gappy");
      exp_q.push_back({9'h000, 32'hDEAD_BEEF});
      send_byte(8'hEF, 0); send_byte(8'hBE, 2); send_byte(8'hAD, 1); send_byte(8'hDE, 0);
      finish_session("gappy", 1, 20);

      // Empty session.
      begin_session(8'd0, "empty");
      @(negedge clk);
      check("empty_done_pulse", 32'(done), 32'd0);
      check("empty_hold", 32'(cpu_hold), 32'd0);
      check("empty_no_write", 32'(writes), 32'd0);

      // Oversized request is clamped to the full memory.
      begin_session(8'd255, "clamp");
      for (int i = 0; i < 128; i++) begin
         w = $urandom;
         exp_q.push_back({AW'(4 * i), w});
         send_word(w, 0);
      end
      finish_session("clamp", 128, 20);
      check("clamp_last_wa", 32'(last_wa), 32'h1FC);

      // Reset in the middle of a word, then a clean restart.
      begin_session(8'd3, "abort");
      send_byte(8'hAA, 0);
      send_byte(8'hBB, 0);
      @(negedge clk);
      byte_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("abort_we", 32'(we), 32'd0);
      check("abort_byte_ready", 32'(byte_ready), 32'd0);
      check("abort_cpu_hold", 32'(cpu_hold), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_wa", 32'(wa), 32'd0);
      check("abort_wd", wd, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      byte_valid = 1'b1;
      byte_data = 8'h5C;
      repeat (3) @(negedge clk);
      check("idle_no_ready", 32'(byte_ready), 32'd0);
      byte_valid = 1'b0;
      check("abort_no_write", 32'(writes), 32'd0);
      begin_session(8'd1, "restart");
      exp_q.push_back({9'h000, 32'h0403_0201});
      send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
      finish_session("restart", 1, 20);

      // start during COLLECT must not disturb the session.
      begin_session(8'd2, "restart_ignored");
      exp_q.push_back({9'h000, 32'h1122_3344});
      exp_q.push_back({9'h004, 32'h5566_7788});
      send_byte(8'h44, 0);
      send_byte(8'h33, 0);
      @(negedge clk);
      byte_valid = 1'b0;
      start = 1'b1;
      num_words = 8'd1;
      @(negedge clk);
      start = 1'b0;
      check("ignored_start_wa", 32'(wa), 32'd0);
      check("ignored_start_hold", 32'(cpu_hold), 32'd1);
      send_byte(8'h22, 0); send_byte(8'h11, 0);
      send_byte(8'h88, 0); send_byte(8'h77, 0); send_byte(8'h66, 0); send_byte(8'h55, 0);
      finish_session("restart_ignored", 2, 20);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter INS_ADDRESS, default 9, meaning instruction memory byte-address width.
REQ-002 SHALL have parameter INS_W, default 32, meaning instruction word width; only 32 is supported.
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  begin load session; sampled only in IDLE.
REQ-006 SHALL have port num_words  input  INS_ADDRESS-1  words to load; sampled with start.
REQ-007 SHALL have port byte_valid  input  1  byte_data holds a valid byte.
REQ-008 SHALL have port byte_data  input  8  incoming program byte.
REQ-009 SHALL have port byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 SHALL have port we  output  1  instruction memory write enable.
REQ-011 SHALL have port wa  output  INS_ADDRESS  memory byte write address; bits [1:0] always 0.
REQ-012 SHALL have port wd  output  INS_W  memory write data.
REQ-013 SHALL have port cpu_hold  output  1  holds the core in reset while loading.
REQ-014 SHALL have port done  output  1  one-cycle pulse marking session end.

Function
REQ-015 SHALL implement states IDLE, COLLECT, WRITE, DONE.
REQ-016 IDLE: start=1 with num_words!=0 -> COLLECT, with wa cleared to 0, byte counter cleared to 0, and words_left loaded; start=1 with num_words=0 -> DONE.
REQ-017 SHALL clamp num_words above 2**(INS_ADDRESS-2) to 2**(INS_ADDRESS-2), so wa never wraps.
REQ-018 byte_ready SHALL be 1 only in COLLECT, driven from registered state only and never combinationally from byte_valid.
REQ-019 A byte SHALL be accepted only on a cycle with byte_valid=1 and byte_ready=1; byte_data SHALL be ignored otherwise.
REQ-020 Bytes SHALL be assembled little-endian: the first accepted byte goes to wd[7:0] and the fourth to wd[31:24].
REQ-021 The cycle after the fourth byte is accepted, the state SHALL be WRITE with we=1 for exactly one cycle, and wa/wd SHALL be stable for that cycle.
REQ-022 WRITE -> DONE when words_left reaches 1; otherwise WRITE -> COLLECT with wa+=4, words_left-=1, and byte counter reset.
REQ-023 DONE SHALL assert done=1 for one cycle, then go to IDLE.
REQ-024 cpu_hold SHALL be 1 in COLLECT and WRITE and 0 in IDLE and DONE.
REQ-025 start SHALL be ignored outside IDLE.
REQ-026 byte_valid gaps of any length SHALL stall assembly with no data loss and no timeout.
REQ-027 we SHALL be 0 in every state except WRITE.

Reset
REQ-028 On rst_n=0, asynchronously: state=IDLE, byte_ready=0, we=0, wa=0, wd=0, cpu_hold=0, done=0, counters=0.
REQ-029 Reset asserted mid-session SHALL discard any partial word, and no write SHALL occur until a new start.
REQ-030 After rst_n deasserts, the first active edge SHALL behave as in IDLE.

Verification
REQ-031 Stimulus: start with num_words=2, then bytes 13,00,00,00,93,00,10,00 sent back-to-back -> response: we pulses twice, first with wa=0x000/wd=0x00000013, second with wa=0x004/wd=0x00100093; done pulses one cycle after the second write; cpu_hold=1 from the cycle after start until DONE.
REQ-032 Stimulus: num_words=1 with byte_valid toggling 1,0,0,1,0,1,1 over bytes EF,BE,AD,DE -> response: a single write of wd=0xDEADBEEF at wa=0, with no extra writes.
REQ-033 Stimulus: start with num_words=0 -> response: done=1 on the next cycle, we is never asserted, cpu_hold stays 0.
REQ-034 Stimulus: num_words=255 with INS_ADDRESS=9 -> response: 128 writes, the last at wa=0x1FC, then done.
REQ-035 Stimulus: rst_n pulled low after 2 bytes of a word, then a restart with 4 bytes 01,02,03,04 -> response: all outputs reset immediately and one write of wd=0x04030201 at wa=0.
REQ-036 Stimulus: start pulsed during COLLECT -> response: ignored, with wa and words_left unchanged.
